frogger_game_ctrl: RTL and testbench

Parametrised game-logic core for the Frogger top level. It sits between the four debounced direction switches and the sprite/VGA renderer. It owns the frog position on a tile grid, a configurable number of obstacle lanes, collision detection, score and lives, and the game state machine. The frog-movement path generalises from fixed 9-bit pixel coordinates to tile coordinates with edge-triggered, bounded moves and full play/death/game-over sequencing.

---
 rtl/frogger_game_ctrl_pkg.sv | 23 ++
 rtl/frogger_game_ctrl_lane_obstacle.sv | 54 +++++
 rtl/frogger_game_ctrl.sv | 143 ++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_game_ctrl_pkg.sv
// Shared definitions for the frogger game-logic core:
// state codes, default grid size and start-tile helpers.
package frogger_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int DEF_GRID_W = 20;
  localparam int DEF_GRID_H = 15;

  function automatic int start_x(input int grid_w);
    return grid_w / 2;
  endfunction

  function automatic int start_y(input int grid_h);
    return grid_h - 1;
  endfunction

endpackage

// File: rtl/frogger_game_ctrl_lane_obstacle.sv
// One obstacle lane: frame divider plus a wrapping car column.
// DIR=0 moves right from column 0, DIR=1 moves left from the last column.
module lane_obstacle
  import frogger_game_ctrl_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int PERIOD = 8,
  parameter bit DIR    = 1'b0
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic                      i_Restart,
  input  logic                      i_Run,
  input  logic                      i_Frame_Tick,
  output logic [$clog2(GRID_W)-1:0] o_Car_X
);

  localparam int XW = $clog2(GRID_W);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [XW-1:0] X_RST = DIR ? X_MAX : '0;
  localparam logic [CW-1:0] C_TOP = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic          adv;
  logic          step;

  assign adv  = i_Run && i_Frame_Tick;
  assign step = adv && (cnt_q == C_TOP);

  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    if (adv) cnt_d = step ? '0 : cnt_q + 1'b1;
    if (step) begin
      if (DIR) x_d = (x_q == '0) ? X_MAX : x_q - 1'b1;
      else     x_d = (x_q == X_MAX) ? '0 : x_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Restart) begin
      cnt_q <= '0;
      x_q   <= X_RST;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
    end
  end

  assign o_Car_X = x_q;

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game core: press detection, frog motion, lanes,
// collision, score/lives and the IDLE/PLAY/HIT/OVER sequencer.
module frogger_game_ctrl
  import frogger_game_ctrl_pkg::*;
#(
  parameter int GRID_W       = DEF_GRID_W,
  parameter int GRID_H       = DEF_GRID_H,
  parameter int LANES        = 4,
  parameter int SPEED_DIV    = 8,
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int SCORE_W      = 7,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(LIVES + 1)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Frame_Tick,
  input  logic                  i_Up,
  input  logic                  i_Dn,
  input  logic                  i_Lt,
  input  logic                  i_Rt,
  output logic [XW-1:0]         o_Frog_X,
  output logic [YW-1:0]         o_Frog_Y,
  output logic [LANES*XW-1:0]   o_Car_X,
  output logic [SCORE_W-1:0]    o_Score,
  output logic [LW-1:0]         o_Lives,
  output logic [1:0]            o_State
);

  localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [XW-1:0] X0    = XW'(start_x(GRID_W));
  localparam logic [YW-1:0] Y0    = YW'(start_y(GRID_H));
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
  localparam logic [DW-1:0] D_TOP = DW'(DEATH_FRAMES - 1);
  localparam logic [LW-1:0] L_INI = LW'(LIVES);

  // press vectors are ordered {up, dn, lt, rt}
  logic [3:0]          btn_q;
  logic [3:0]          press_q;
  state_e              state_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [SCORE_W-1:0]  score_q;
  logic [LW-1:0]       lives_q;
  logic [DW-1:0]       death_q;
  logic [LANES*XW-1:0] car_x;
  logic                any_press;
  logic                restart;
  logic                run;
  logic                hit;

  assign any_press = |press_q;
  assign restart   = (state_q == ST_OVER) && any_press;
  assign run       = (state_q == ST_PLAY);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_obstacle #(
      .GRID_W (GRID_W),
      .PERIOD ((k + 1) * SPEED_DIV),
      .DIR    (1'(k % 2))
    ) u_lane (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Restart    (restart),
      .i_Run        (run),
      .i_Frame_Tick (i_Frame_Tick),
      .o_Car_X      (car_x[k*XW +: XW])
    );
  end

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (y_q == YW'(k + 1) && x_q == car_x[k*XW +: XW]) hit = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      btn_q   <= '0;
      press_q <= '0;
      state_q <= ST_IDLE;
      x_q     <= X0;
      y_q     <= Y0;
      score_q <= '0;
      lives_q <= L_INI;
      death_q <= '0;
    end else begin
      btn_q   <= {i_Up, i_Dn, i_Lt, i_Rt};
      press_q <= {i_Up, i_Dn, i_Lt, i_Rt} & ~btn_q;
      unique case (state_q)
        ST_IDLE: if (any_press) state_q <= ST_PLAY;
        ST_PLAY: begin
          if (hit) begin
            state_q <= ST_HIT;
          end else if (y_q == '0) begin
            if (score_q != '1) score_q <= score_q + 1'b1;
            x_q <= X0;
            y_q <= Y0;
          end else if (press_q[3]) begin
            if (y_q != '0) y_q <= y_q - 1'b1;
          end else if (press_q[2]) begin
            if (y_q != Y_MAX) y_q <= y_q + 1'b1;
          end else if (press_q[1]) begin
            if (x_q != '0) x_q <= x_q - 1'b1;
          end else if (press_q[0]) begin
            if (x_q != X_MAX) x_q <= x_q + 1'b1;
          end
        end
        ST_HIT: if (i_Frame_Tick) begin
          if (death_q == D_TOP) begin
            death_q <= '0;
            lives_q <= lives_q - 1'b1;
            x_q     <= X0;
            y_q     <= Y0;
            state_q <= (lives_q == LW'(1)) ? ST_OVER : ST_PLAY;
          end else begin
            death_q <= death_q + 1'b1;
          end
        end
        ST_OVER: if (any_press) begin
          state_q <= ST_IDLE;
          score_q <= '0;
          lives_q <= L_INI;
          x_q     <= X0;
          y_q     <= Y0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Frog_X = x_q;
  assign o_Frog_Y = y_q;
  assign o_Car_X  = car_x;
  assign o_Score  = score_q;
  assign o_Lives  = lives_q;
  assign o_State  = state_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Bench for frogger_game_ctrl: directed scenarios plus a random
// run, all judged against a tick-counting game model.
module tb_frogger_game_ctrl;

  localparam int GW = 20;
  localparam int GH = 15;
  localparam int LN = 2;
  localparam int SD = 2;
  localparam int LV = 2;
  localparam int DF = 60;
  localparam int SW = 7;
  localparam int XW = $clog2(GW);
  localparam int YW = $clog2(GH);
  localparam int LW = $clog2(LV + 1);
  localparam int VW = 2 + XW + YW + SW + LW + LN * XW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic up = 1'b0, dn = 1'b0, lt = 1'b0, rt = 1'b0;
  logic [XW-1:0]    o_Frog_X;
  logic [YW-1:0]    o_Frog_Y;
  logic [LN*XW-1:0] o_Car_X;
  logic [SW-1:0]    o_Score;
  logic [LW-1:0]    o_Lives;
  logic [1:0]       o_State;

  int n_chk = 0;
  int n_pass = 0;

  frogger_game_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .LANES(LN), .SPEED_DIV(SD),
    .LIVES(LV), .DEATH_FRAMES(DF), .SCORE_W(SW)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Frame_Tick(tick),
    .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
    .o_Frog_X(o_Frog_X), .o_Frog_Y(o_Frog_Y), .o_Car_X(o_Car_X),
    .o_Score(o_Score), .o_Lives(o_Lives), .o_State(o_State)
  );

  always #5 clk = ~clk;

  // game model: car positions derive from ticks seen while playing
  int m_st, m_x, m_y, m_score, m_lives, m_death;
  int mt[LN];
  logic [3:0] m_prev, m_pend;

  function automatic int car(input int k);
    int s;
    s = (mt[k] / ((k + 1) * SD)) % GW;
    return (k % 2 == 0) ? s : GW - 1 - s;
  endfunction

  always @(posedge clk) begin
    logic [3:0] pv, lvl;
    bit h;
    if (rst) begin
      m_st = 0; m_x = GW / 2; m_y = GH - 1; m_score = 0;
      m_lives = LV; m_death = 0; m_prev = '0; m_pend = '0;
      for (int k = 0; k < LN; k++) mt[k] = 0;
    end else begin
      h = 0;
      for (int k = 0; k < LN; k++)
        if (m_y == k + 1 && m_x == car(k)) h = 1;
      lvl = {up, dn, lt, rt};
      pv = m_pend;
      m_pend = lvl & ~m_prev;
      m_prev = lvl;
      case (m_st)
        0: if (pv != 0) m_st = 1;
        1: begin
          if (tick) for (int k = 0; k < LN; k++) mt[k]++;
          if (h) m_st = 2;
          else if (m_y == 0) begin
            m_score = (m_score == (1 << SW) - 1) ? m_score : m_score + 1;
            m_x = GW / 2; m_y = GH - 1;
          end
          else if (pv[3]) begin if (m_y > 0) m_y--; end
          else if (pv[2]) begin if (m_y < GH - 1) m_y++; end
          else if (pv[1]) begin if (m_x > 0) m_x--; end
          else if (pv[0]) begin if (m_x < GW - 1) m_x++; end
        end
        2: if (tick) begin
          if (m_death == DF - 1) begin
            m_death = 0;
            m_st = (m_lives == 1) ? 3 : 1;
            m_lives--;
            m_x = GW / 2; m_y = GH - 1;
          end else m_death++;
        end
        default: if (pv != 0) begin
          m_st = 0; m_score = 0; m_lives = LV;
          m_x = GW / 2; m_y = GH - 1;
          for (int k = 0; k < LN; k++) mt[k] = 0;
        end
      endcase
    end
  end

  function automatic logic [VW-1:0] dut_vec();
    return {o_State, o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Car_X};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    logic [LN*XW-1:0] c;
    for (int k = 0; k < LN; k++) c[k*XW +: XW] = XW'(car(k));
    return {2'(m_st), XW'(m_x), YW'(m_y), SW'(m_score), LW'(m_lives), c};
  endfunction

  task automatic press(input logic [3:0] b);
    {up, dn, lt, rt} = b;
    @(negedge clk);
    {up, dn, lt, rt} = 4'b0000;
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o_State, o_Frog_X, o_Frog_Y} !== {2'd0, 5'd10, 4'd14})
      $display("FAIL reset_frog: st=%0d x=%0d y=%0d want 0/10/14", o_State, o_Frog_X, o_Frog_Y);
    else n_pass++;
    n_chk++;
    if ({o_Score, o_Lives, o_Car_X} !== {7'd0, 2'd2, 5'd19, 5'd0})
      $display("FAIL reset_misc: score=%0d lives=%0d cars=%h", o_Score, o_Lives, o_Car_X);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dut_vec() !== mdl_vec())
      $display("FAIL reset_model: got %h want %h", dut_vec(), mdl_vec());
    else n_pass++;
  endtask

  task automatic test_first_press();
    press(4'b1000);
    n_chk++;
    if ({o_State, o_Frog_X, o_Frog_Y} !== {2'd1, 5'd10, 4'd14})
      $display("FAIL start_press: st=%0d x=%0d y=%0d want 1/10/14", o_State, o_Frog_X, o_Frog_Y);
    else n_pass++;
    up = 1'b1;
    @(negedge clk);
    n_chk++;
    if (o_Frog_Y !== 4'd14)
      $display("FAIL move_latency: y=%0d want 14 one cycle after edge", o_Frog_Y);
    else n_pass++;
    up = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({o_Frog_X, o_Frog_Y} !== {5'd10, 4'd13})
      $display("FAIL up_move: x=%0d y=%0d want 10/13", o_Frog_X, o_Frog_Y);
    else n_pass++;
  endtask

  task automatic test_bounds();
    press(4'b0100);
    repeat (11) press(4'b0010);
    n_chk++;
    if ({o_Frog_X, o_Frog_Y} !== {5'd0, 4'd14})
      $display("FAIL left_edge: x=%0d y=%0d want 0/14", o_Frog_X, o_Frog_Y);
    else n_pass++;
    press(4'b0100);
    n_chk++;
    if (o_Frog_Y !== 4'd14)
      $display("FAIL bottom_edge: y=%0d want 14", o_Frog_Y);
    else n_pass++;
    press(4'b1001);
    n_chk++;
    if ({o_Frog_X, o_Frog_Y} !== {5'd0, 4'd13})
      $display("FAIL priority: x=%0d y=%0d want 0/13", o_Frog_X, o_Frog_Y);
    else n_pass++;
    n_chk++;
    if (dut_vec() !== mdl_vec())
      $display("FAIL bounds_model: got %h want %h", dut_vec(), mdl_vec());
    else n_pass++;
  endtask

  task automatic test_lanes();
    logic [XW-1:0] c0, c1;
    for (int t = 1; t <= 80; t++) begin
      pulse_tick();
      n_chk++;
      if (dut_vec() !== mdl_vec())
        $display("FAIL lanes_model t=%0d: got %h want %h", t, dut_vec(), mdl_vec());
      else n_pass++;
      c0 = XW'((t / 2) % GW);
      c1 = XW'(GW - 1 - (t / 4) % GW);
      if (t == 2 || t == 4 || t == 38 || t == 40 || t == 76 || t == 80) begin
        n_chk++;
        if ({o_Car_X[9:5], o_Car_X[4:0]} !== {c1, c0})
          $display("FAIL lane_pos t=%0d: got %0d/%0d want %0d/%0d",
                   t, o_Car_X[4:0], o_Car_X[9:5], c0, c1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_collision();
    repeat (12) press(4'b1000);
    n_chk++;
    if ({o_State, o_Frog_Y} !== {2'd1, 4'd1})
      $display("FAIL row1_entry: st=%0d y=%0d want 1/1", o_State, o_Frog_Y);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (o_State !== 2'd2)
      $display("FAIL hit_state: st=%0d want 2", o_State);
    else n_pass++;
    press(4'b1000);
    repeat (59) pulse_tick();
    n_chk++;
    if ({o_State, o_Lives} !== {2'd2, 2'd2})
      $display("FAIL hit_hold: st=%0d lives=%0d want 2/2", o_State, o_Lives);
    else n_pass++;
    pulse_tick();
    n_chk++;
    if ({o_State, o_Lives, o_Frog_X, o_Frog_Y} !== {2'd1, 2'd1, 5'd10, 4'd14})
      $display("FAIL death_end: st=%0d lives=%0d x=%0d y=%0d", o_State, o_Lives, o_Frog_X, o_Frog_Y);
    else n_pass++;
    n_chk++;
    if (dut_vec() !== mdl_vec())
      $display("FAIL collide_model: got %h want %h", dut_vec(), mdl_vec());
    else n_pass++;
  endtask

  task automatic test_game_over();
    repeat (3) pulse_tick();
    repeat (9) press(4'b0010);
    repeat (13) press(4'b1000);
    @(negedge clk);
    n_chk++;
    if (o_State !== 2'd2)
      $display("FAIL hit2_state: st=%0d want 2", o_State);
    else n_pass++;
    repeat (60) pulse_tick();
    n_chk++;
    if ({o_State, o_Lives} !== {2'd3, 2'd0})
      $display("FAIL over_state: st=%0d lives=%0d want 3/0", o_State, o_Lives);
    else n_pass++;
    repeat (5) pulse_tick();
    press(4'b0001);
    n_chk++;
    if ({o_State, o_Score, o_Lives, o_Car_X} !== {2'd0, 7'd0, 2'd2, 5'd19, 5'd0})
      $display("FAIL over_restart: st=%0d score=%0d lives=%0d cars=%h",
               o_State, o_Score, o_Lives, o_Car_X);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) up = ~up;
      if ($urandom_range(3) == 0) dn = ~dn;
      if ($urandom_range(3) == 0) lt = ~lt;
      if ($urandom_range(3) == 0) rt = ~rt;
      tick = ($urandom_range(2) == 0);
      @(negedge clk);
      n_chk++;
      if (dut_vec() !== mdl_vec())
        $display("FAIL random_model cyc=%0d: got %h want %h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
    {up, dn, lt, rt} = 4'b0000;
    tick = 1'b0;
  endtask

  task automatic test_score_sat();
    int want;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    press(4'b1000);
    for (int i = 0; i < 128; i++) begin
      repeat (14) press(4'b1000);
      @(negedge clk);
      want = (i + 1 > 127) ? 127 : i + 1;
      n_chk++;
      if ({o_Score, o_Frog_X, o_Frog_Y} !== {7'(want), 5'd10, 4'd14})
        $display("FAIL crossing %0d: score=%0d x=%0d y=%0d want %0d/10/14",
                 i, o_Score, o_Frog_X, o_Frog_Y, want);
      else n_pass++;
    end
    n_chk++;
    if (dut_vec() !== mdl_vec())
      $display("FAIL score_model: got %h want %h", dut_vec(), mdl_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid_hit();
    repeat (20) pulse_tick();
    repeat (13) press(4'b1000);
    @(negedge clk);
    n_chk++;
    if (o_State !== 2'd2)
      $display("FAIL hit3_state: st=%0d want 2", o_State);
    else n_pass++;
    repeat (5) pulse_tick();
    rst = 1'b1;
    up = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_State, o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Car_X} !==
        {2'd0, 5'd10, 4'd14, 7'd0, 2'd2, 5'd19, 5'd0})
      $display("FAIL reset_mid_hit: got %h", dut_vec());
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (o_State !== 2'd0)
      $display("FAIL held_press_early: st=%0d want 0", o_State);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (o_State !== 2'd1)
      $display("FAIL held_press: st=%0d want 1", o_State);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o_Frog_X, o_Frog_Y} !== {5'd10, 4'd14})
      $display("FAIL held_once: x=%0d y=%0d want 10/14", o_Frog_X, o_Frog_Y);
    else n_pass++;
    up = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dut_vec() !== mdl_vec())
      $display("FAIL final_model: got %h want %h", dut_vec(), mdl_vec());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_press();
    test_bounds();
    test_lanes();
    test_collision();
    test_game_over();
    test_random();
    test_score_sat();
    test_reset_mid_hit();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
